// File: rtl/uart_pkg.sv
// Shared register map, bit positions and FSM state encodings for the OBI UART.
package uart_pkg;

  localparam int unsigned DIV_W = 16;
  localparam int unsigned OFF_W = 3;

  localparam logic [OFF_W-1:0] UART_CTRL   = 3'd0;
  localparam logic [OFF_W-1:0] UART_STATUS = 3'd1;
  localparam logic [OFF_W-1:0] UART_BAUD   = 3'd2;
  localparam logic [OFF_W-1:0] UART_TXDATA = 3'd3;
  localparam logic [OFF_W-1:0] UART_RXDATA = 3'd4;

  localparam int unsigned CTRL_TX_EN = 0;
  localparam int unsigned CTRL_RX_EN = 1;
  localparam int unsigned CTRL_TX_IE = 2;
  localparam int unsigned CTRL_RX_IE = 3;

  localparam int unsigned STAT_TX_BUSY      = 0;
  localparam int unsigned STAT_TX_FULL      = 1;
  localparam int unsigned STAT_TX_EMPTY     = 2;
  localparam int unsigned STAT_RX_VALID     = 3;
  localparam int unsigned STAT_RX_OVERRUN   = 4;
  localparam int unsigned STAT_RX_FRAME_ERR = 5;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

endpackage

// File: rtl/obi_uart_if.sv
// OBI slave-port signal bundle for the UART peripheral.
interface obi_uart_if;
  logic        req_i;
  logic        gnt_o;
  logic        rvalid_o;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;

  modport master (output req_i, we_i, be_i, addr_i, wdata_i,
                  input  gnt_o, rvalid_o, rdata_o);
  modport slave  (input  req_i, we_i, be_i, addr_i, wdata_i,
                  output gnt_o, rvalid_o, rdata_o);
endinterface

// File: rtl/uart_tx_fifo.sv
// Generic synchronous FIFO; extra pointer MSB distinguishes full from empty.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned AW = PW + 1;

  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
  assign data_o  = mem_q[rptr_q[PW-1:0]];

  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  always_comb begin
    do_pop  = pop_i & ~empty_o;
    do_push = push_i & (~full_o | do_pop);
    wptr_d  = wptr_q + AW'(do_push);
    rptr_d  = rptr_q + AW'(do_pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      if (do_push) mem_q[wptr_q[PW-1:0]] <= data_i;
    end
  end
endmodule

// File: rtl/obi_uart.sv
// OBI-attached 8N1 UART: register file, buffered transmitter, single-entry receiver.
module obi_uart
  import uart_pkg::*;
#(
  parameter int unsigned TX_FIFO_DEPTH = 4,
  parameter logic [15:0] DEFAULT_DIV   = 16'd433
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  obi_uart_if.slave bus,
  output logic      tx_o,
  input  logic      rx_i,
  output logic      irq_o
);
  logic [OFF_W-1:0] off;
  logic             wr_req, rd_req;
  logic [3:0]       ctrl_q, ctrl_d;
  logic [DIV_W-1:0] baud_q, baud_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;
  logic             push, pop, fifo_full, fifo_empty;
  logic [7:0]       fifo_rdata;
  logic             clr_ovr, clr_fe, rx_rd;
  logic [5:0]       status;
  logic             tx_busy, tx_empty, rx_fall;
  logic             unused_bits;

  tx_state_e        tx_state_q, tx_state_d;
  logic [DIV_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic             tx_q, tx_d;

  rx_state_e        rx_state_q, rx_state_d;
  logic [DIV_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d, rx_ovr_q, rx_ovr_d, rx_fe_q, rx_fe_d;
  logic             rx_meta_q, rx_sync_q, rx_prev_q;
  logic             irq_q, irq_d;

  assign off         = bus.addr_i[4:2];
  assign wr_req      = bus.req_i & bus.we_i;
  assign rd_req      = bus.req_i & ~bus.we_i;
  assign bus.gnt_o   = bus.req_i;
  assign bus.rvalid_o = rvalid_q;
  assign bus.rdata_o = rdata_q;
  assign tx_o        = tx_q;
  assign irq_o       = irq_q;
  assign unused_bits = ^{bus.addr_i[31:5], bus.addr_i[1:0], bus.wdata_i[31:16], bus.be_i[3:2]};

  assign tx_busy  = (tx_state_q != TX_IDLE);
  assign tx_empty = fifo_empty & ~tx_busy;
  assign rx_fall  = rx_prev_q & ~rx_sync_q;

  always_comb begin
    status                    = '0;
    status[STAT_TX_BUSY]      = tx_busy;
    status[STAT_TX_FULL]      = fifo_full;
    status[STAT_TX_EMPTY]     = tx_empty;
    status[STAT_RX_VALID]     = rx_valid_q;
    status[STAT_RX_OVERRUN]   = rx_ovr_q;
    status[STAT_RX_FRAME_ERR] = rx_fe_q;
  end

  // Register file: every request is granted and answered one cycle later.
  always_comb begin
    ctrl_d   = ctrl_q;
    baud_d   = baud_q;
    rdata_d  = '0;
    rvalid_d = bus.req_i;
    push     = 1'b0;
    clr_ovr  = 1'b0;
    clr_fe   = 1'b0;
    rx_rd    = 1'b0;
    if (wr_req) begin
      case (off)
        UART_CTRL:   if (bus.be_i[0]) ctrl_d = bus.wdata_i[3:0];
        UART_STATUS: if (bus.be_i[0]) begin
          clr_ovr = bus.wdata_i[STAT_RX_OVERRUN];
          clr_fe  = bus.wdata_i[STAT_RX_FRAME_ERR];
        end
        UART_BAUD: begin
          if (bus.be_i[0]) baud_d[7:0]  = bus.wdata_i[7:0];
          if (bus.be_i[1]) baud_d[15:8] = bus.wdata_i[15:8];
        end
        UART_TXDATA: push = bus.be_i[0];
        default: ;
      endcase
    end
    if (rd_req) begin
      case (off)
        UART_CTRL:   rdata_d = 32'(ctrl_q);
        UART_STATUS: rdata_d = 32'(status);
        UART_BAUD:   rdata_d = 32'(baud_q);
        UART_RXDATA: begin
          rdata_d = 32'({rx_valid_q, rx_data_q});
          rx_rd   = rx_valid_q;
        end
        default: ;
      endcase
    end
  end

  uart_tx_fifo #(.DEPTH(TX_FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (push),
    .data_i (bus.wdata_i[7:0]),
    .pop_i  (pop),
    .data_o (fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  // Transmitter: the bit counter reloads from BAUD at every bit boundary.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    pop        = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        tx_d = 1'b1;
        if (ctrl_q[CTRL_TX_EN] && !fifo_empty) begin
          pop        = 1'b1;
          tx_shift_d = fifo_rdata;
          tx_cnt_d   = baud_q;
          tx_state_d = TX_START;
          tx_d       = 1'b0;
        end
      end
      TX_START: if (tx_cnt_q == '0) begin
        tx_state_d = TX_DATA;
        tx_cnt_d   = baud_q;
        tx_bit_d   = '0;
        tx_d       = tx_shift_q[0];
      end else tx_cnt_d = tx_cnt_q - DIV_W'(1);
      TX_DATA: if (tx_cnt_q == '0) begin
        tx_cnt_d = baud_q;
        if (tx_bit_q == 3'd7) begin
          tx_state_d = TX_STOP;
          tx_d       = 1'b1;
        end else begin
          tx_bit_d   = tx_bit_q + 3'd1;
          tx_shift_d = tx_shift_q >> 1;
          tx_d       = tx_shift_q[1];
        end
      end else tx_cnt_d = tx_cnt_q - DIV_W'(1);
      TX_STOP: if (tx_cnt_q == '0) tx_state_d = TX_IDLE;
               else tx_cnt_d = tx_cnt_q - DIV_W'(1);
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // Receiver: sample mid-bit; a completed frame beats a same-cycle RXDATA read.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q & ~rx_rd;
    rx_ovr_d   = rx_ovr_q & ~clr_ovr;
    rx_fe_d    = rx_fe_q & ~clr_fe;
    if (!ctrl_q[CTRL_RX_EN]) begin
      rx_state_d = RX_IDLE;
    end else begin
      case (rx_state_q)
        RX_IDLE: if (rx_fall) begin
          rx_state_d = RX_START;
          rx_cnt_d   = baud_q >> 1;
        end
        RX_START: if (rx_cnt_q == '0) begin
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
          rx_cnt_d   = baud_q;
          rx_bit_d   = '0;
        end else rx_cnt_d = rx_cnt_q - DIV_W'(1);
        RX_DATA: if (rx_cnt_q == '0) begin
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_cnt_d   = baud_q;
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end else rx_cnt_d = rx_cnt_q - DIV_W'(1);
        RX_STOP: if (rx_cnt_q == '0) begin
          rx_state_d = RX_IDLE;
          if (rx_sync_q) begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
            if (rx_valid_q) rx_ovr_d = 1'b1;
          end else begin
            rx_fe_d = 1'b1;
          end
        end else rx_cnt_d = rx_cnt_q - DIV_W'(1);
        default: rx_state_d = RX_IDLE;
      endcase
    end
    irq_d = (rx_valid_q & ctrl_q[CTRL_RX_IE]) | (tx_empty & ctrl_q[CTRL_TX_IE]);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_q     <= '0;
      baud_q     <= DEFAULT_DIV;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
      rx_fe_q    <= 1'b0;
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      irq_q      <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      baud_q     <= baud_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_ovr_q   <= rx_ovr_d;
      rx_fe_q    <= rx_fe_d;
      rx_meta_q  <= rx_i;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      irq_q      <= irq_d;
    end
  end
endmodule

// File: tb/tb_obi_uart.sv
// Scenario bench for obi_uart: register access, TX framing, RX framing and errors.
module tb_obi_uart;
  logic clk, rst_n, rx, tx, irq;
  int   total, bad;

  logic [31:0] exp_q[$];
  logic [7:0]  tx_exp_q[$];
  logic        bit_q[$];

  obi_uart_if bus_if ();

  obi_uart #(.TX_FIFO_DEPTH(4), .DEFAULT_DIV(16'd433)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus_if),
    .tx_o  (tx),
    .rx_i  (rx),
    .irq_o (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic bus_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, output logic rv, output logic [31:0] rd);
    @(negedge clk);
    bus_if.req_i = 1'b1; bus_if.we_i = we; bus_if.addr_i = addr;
    bus_if.wdata_i = wdata; bus_if.be_i = be;
    @(negedge clk);
    rv = bus_if.rvalid_o; rd = bus_if.rdata_o;
    bus_if.req_i = 1'b0; bus_if.we_i = 1'b0;
  endtask

  // Drives one 8N1 frame with the given stop level, then returns the line high.
  task automatic send_rx(input logic [7:0] b, input logic stop, input int per);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); rx = bits[i];
      repeat (per - 1) @(negedge clk);
    end
    @(negedge clk); rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Decodes one frame from tx at 4 cycles per bit, sampling mid-bit.
  task automatic tx_decode(output logic [7:0] b, output logic stop, output logic ok);
    ok = 1'b0; b = '0; stop = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin ok = 1'b1; break; end
    end
    if (ok) begin
      @(negedge clk);
      for (int k = 0; k < 8; k++) begin
        repeat (4) @(negedge clk);
        b[k] = tx;
      end
      repeat (4) @(negedge clk);
      stop = tx;
    end
  endtask

  task automatic test_reset();
    logic rv; logic [31:0] rd, e;
    logic [31:0] addrs [6] = '{32'h0, 32'h4, 32'h8, 32'h10, 32'hC, 32'h14};
    logic [31:0] exps  [6] = '{32'h0, 32'h4, 32'h1B1, 32'h0, 32'h0, 32'h0};
    rst_n = 1'b0; rx = 1'b1;
    bus_if.req_i = 0; bus_if.we_i = 0; bus_if.addr_i = 0; bus_if.wdata_i = 0; bus_if.be_i = 0;
    repeat (3) @(negedge clk);
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx got %b want 1", tx); end
    total++; if (bus_if.rvalid_o !== 1'b0) begin bad++; $display("FAIL reset_rvalid got %b want 0", bus_if.rvalid_o); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got %b want 0", irq); end
    total++; if (bus_if.rdata_o !== 32'h0) begin bad++; $display("FAIL reset_rdata got %h want 0", bus_if.rdata_o); end
    rst_n = 1'b1;
    @(negedge clk);
    bus_if.req_i = 1'b1; #1;
    total++; if (bus_if.gnt_o !== 1'b1) begin bad++; $display("FAIL gnt_comb got %b want 1", bus_if.gnt_o); end
    bus_if.req_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(exps[i]);
      bus_xfer(1'b0, addrs[i], 32'h0, 4'hF, rv, rd);
      e = exp_q.pop_front();
      total++; if (rv !== 1'b1 || rd !== e) begin bad++; $display("FAIL reset_read[%0d] got rv=%b %h want rv=1 %h", i, rv, rd, e); end
    end
  endtask

  task automatic test_regs();
    logic rv; logic [31:0] rd, e;
    bus_xfer(1'b1, 32'h8, 32'h0000_1234, 4'h1, rv, rd);
    total++; if (rv !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL write_resp got rv=%b %h want rv=1 0", rv, rd); end
    exp_q.push_back(32'h0000_01_34);
    bus_xfer(1'b0, 32'h8, 32'h0, 4'hF, rv, rd); e = exp_q.pop_front();
    total++; if (rd !== e) begin bad++; $display("FAIL baud_be0 got %h want %h", rd, e); end
    bus_xfer(1'b1, 32'h8, 32'h0000_AB00, 4'h2, rv, rd);
    exp_q.push_back(32'h0000_AB34);
    bus_xfer(1'b0, 32'h8, 32'h0, 4'hF, rv, rd); e = exp_q.pop_front();
    total++; if (rd !== e) begin bad++; $display("FAIL baud_be1 got %h want %h", rd, e); end
    bus_xfer(1'b1, 32'h0, 32'h0000_000F, 4'hE, rv, rd);
    exp_q.push_back(32'h0);
    bus_xfer(1'b0, 32'h0, 32'h0, 4'hF, rv, rd); e = exp_q.pop_front();
    total++; if (rd !== e) begin bad++; $display("FAIL ctrl_no_be0 got %h want %h", rd, e); end
  endtask

  task automatic test_tx_frame();
    logic rv, found, eb; logic [31:0] rd, e;
    logic [9:0] seq;
    seq = 10'b11_0100_1010;
    bus_xfer(1'b1, 32'h8, 32'h3, 4'hF, rv, rd);
    bus_xfer(1'b1, 32'h0, 32'h1, 4'hF, rv, rd);
    for (int i = 0; i < 10; i++) repeat (4) bit_q.push_back(seq[i]);
    bus_xfer(1'b1, 32'hC, 32'hA5, 4'h1, rv, rd);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin found = 1'b1; break; end
    end
    total++; if (!found) begin bad++; $display("FAIL tx_start got none want start bit"); end
    if (found) begin
      for (int i = 0; i < 40; i++) begin
        if (i > 0) @(negedge clk);
        eb = bit_q.pop_front();
        total++; if (tx !== eb) begin bad++; $display("FAIL tx_bit[%0d] got %b want %b", i, tx, eb); end
      end
    end
    bit_q.delete();
    repeat (4) @(negedge clk);
    exp_q.push_back(32'h4);
    bus_xfer(1'b0, 32'h4, 32'h0, 4'hF, rv, rd); e = exp_q.pop_front();
    total++; if (rd !== e) begin bad++; $display("FAIL tx_done_status got %h want %h", rd, e); end
  endtask

  task automatic test_back_to_back();
    logic rv, stop, ok, low_seen; logic [31:0] rd, e;
    logic [7:0] b, eb;
    bus_xfer(1'b1, 32'h8, 32'h3, 4'hF, rv, rd);
    bus_xfer(1'b1, 32'h0, 32'h1, 4'hF, rv, rd);
    fork
      begin
        for (int k = 0; k < 5; k++) begin
          tx_decode(b, stop, ok);
          total++;
          if (!ok || tx_exp_q.size() == 0) begin
            bad++; $display("FAIL b2b_frame[%0d] got no frame want byte", k);
          end else begin
            eb = tx_exp_q.pop_front();
            if (b !== eb || stop !== 1'b1) begin
              bad++; $display("FAIL b2b_frame[%0d] got %h stop=%b want %h stop=1", k, b, stop, eb);
            end
          end
        end
      end
      begin
        for (int i = 1; i <= 6; i++) begin
          @(negedge clk);
          if (i > 1) begin
            total++; if (bus_if.rvalid_o !== 1'b1 || bus_if.rdata_o !== 32'h0) begin
              bad++; $display("FAIL b2b_resp[%0d] got rv=%b %h want rv=1 0", i, bus_if.rvalid_o, bus_if.rdata_o);
            end
          end
          bus_if.req_i = 1'b1; bus_if.we_i = 1'b1; bus_if.addr_i = 32'hC;
          bus_if.wdata_i = 32'(i); bus_if.be_i = 4'h1;
          if (i <= 5) tx_exp_q.push_back(8'(i));
        end
        @(negedge clk);
        bus_if.req_i = 1'b0; bus_if.we_i = 1'b0;
        exp_q.push_back(32'h3);
        bus_xfer(1'b0, 32'h4, 32'h0, 4'hF, rv, rd); e = exp_q.pop_front();
        total++; if (rd !== e) begin bad++; $display("FAIL b2b_full_status got %h want %h", rd, e); end
      end
    join
    low_seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) low_seen = 1'b1;
    end
    total++; if (low_seen) begin bad++; $display("FAIL b2b_dropped got extra frame want idle"); end
    exp_q.push_back(32'h4);
    bus_xfer(1'b0, 32'h4, 32'h0, 4'hF, rv, rd); e = exp_q.pop_front();
    total++; if (rd !== e) begin bad++; $display("FAIL b2b_end_status got %h want %h", rd, e); end
  endtask

  task automatic test_rx();
    logic rv; logic [31:0] rd, e;
    bus_xfer(1'b1, 32'h0, 32'h2, 4'hF, rv, rd);
    bus_xfer(1'b1, 32'h8, 32'h7, 4'hF, rv, rd);
    send_rx(8'h3C, 1'b1, 8);
    exp_q.push_back(32'h13C); exp_q.push_back(32'h03C);
    for (int i = 0; i < 2; i++) begin
      bus_xfer(1'b0, 32'h10, 32'h0, 4'hF, rv, rd); e = exp_q.pop_front();
      total++; if (rd !== e) begin bad++; $display("FAIL rx_read[%0d] got %h want %h", i, rd, e); end
    end
  endtask

  task automatic test_overrun();
    logic rv; logic [31:0] rd, e;
    send_rx(8'h11, 1'b1, 8);
    send_rx(8'h22, 1'b1, 8);
    exp_q.push_back(32'h1C);
    bus_xfer(1'b0, 32'h4, 32'h0, 4'hF, rv, rd); e = exp_q.pop_front();
    total++; if (rd !== e) begin bad++; $display("FAIL ovr_status got %h want %h", rd, e); end
    exp_q.push_back(32'h122);
    bus_xfer(1'b0, 32'h10, 32'h0, 4'hF, rv, rd); e = exp_q.pop_front();
    total++; if (rd !== e) begin bad++; $display("FAIL ovr_rxdata got %h want %h", rd, e); end
    bus_xfer(1'b1, 32'h4, 32'h10, 4'hF, rv, rd);
    exp_q.push_back(32'h04);
    bus_xfer(1'b0, 32'h4, 32'h0, 4'hF, rv, rd); e = exp_q.pop_front();
    total++; if (rd !== e) begin bad++; $display("FAIL ovr_clear got %h want %h", rd, e); end
  endtask

  task automatic test_frame_err();
    logic rv; logic [31:0] rd, e;
    send_rx(8'h55, 1'b0, 8);
    exp_q.push_back(32'h24); exp_q.push_back(32'h022);
    bus_xfer(1'b0, 32'h4, 32'h0, 4'hF, rv, rd); e = exp_q.pop_front();
    total++; if (rd !== e) begin bad++; $display("FAIL fe_status got %h want %h", rd, e); end
    bus_xfer(1'b0, 32'h10, 32'h0, 4'hF, rv, rd); e = exp_q.pop_front();
    total++; if (rd !== e) begin bad++; $display("FAIL fe_rxdata got %h want %h", rd, e); end
    @(negedge clk); rx = 1'b0;
    @(negedge clk); rx = 1'b1;
    repeat (30) @(negedge clk);
    exp_q.push_back(32'h24); exp_q.push_back(32'h022);
    bus_xfer(1'b0, 32'h4, 32'h0, 4'hF, rv, rd); e = exp_q.pop_front();
    total++; if (rd !== e) begin bad++; $display("FAIL glitch_status got %h want %h", rd, e); end
    bus_xfer(1'b0, 32'h10, 32'h0, 4'hF, rv, rd); e = exp_q.pop_front();
    total++; if (rd !== e) begin bad++; $display("FAIL glitch_rxdata got %h want %h", rd, e); end
    bus_xfer(1'b1, 32'h4, 32'h20, 4'hF, rv, rd);
    exp_q.push_back(32'h04);
    bus_xfer(1'b0, 32'h4, 32'h0, 4'hF, rv, rd); e = exp_q.pop_front();
    total++; if (rd !== e) begin bad++; $display("FAIL fe_clear got %h want %h", rd, e); end
  endtask

  task automatic test_irq();
    logic rv; logic [31:0] rd, e;
    bus_xfer(1'b1, 32'h0, 32'hA, 4'hF, rv, rd);
    repeat (2) @(negedge clk);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_idle got %b want 0", irq); end
    send_rx(8'h7E, 1'b1, 8);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_rx got %b want 1", irq); end
    exp_q.push_back(32'h17E);
    bus_xfer(1'b0, 32'h10, 32'h0, 4'hF, rv, rd); e = exp_q.pop_front();
    total++; if (rd !== e) begin bad++; $display("FAIL irq_rxdata got %h want %h", rd, e); end
    repeat (2) @(negedge clk);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_rx_clear got %b want 0", irq); end
    bus_xfer(1'b1, 32'h0, 32'h4, 4'hF, rv, rd);
    repeat (2) @(negedge clk);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_tx_empty got %b want 1", irq); end
    bus_xfer(1'b1, 32'h0, 32'h0, 4'hF, rv, rd);
    repeat (2) @(negedge clk);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_off got %b want 0", irq); end
  endtask

  task automatic test_reset_mid_frame();
    logic rv, low_seen; logic [31:0] rd, e;
    bus_xfer(1'b1, 32'h8, 32'h3, 4'hF, rv, rd);
    bus_xfer(1'b1, 32'h0, 32'h1, 4'hF, rv, rd);
    bus_xfer(1'b1, 32'hC, 32'h00, 4'h1, rv, rd);
    bus_xfer(1'b1, 32'hC, 32'h00, 4'h1, rv, rd);
    repeat (6) @(negedge clk);
    total++; if (tx !== 1'b0) begin bad++; $display("FAIL mid_frame_tx got %b want 0", tx); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL async_reset_tx got %b want 1", tx); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(32'h04); exp_q.push_back(32'h1B1);
    bus_xfer(1'b0, 32'h4, 32'h0, 4'hF, rv, rd); e = exp_q.pop_front();
    total++; if (rd !== e) begin bad++; $display("FAIL post_reset_status got %h want %h", rd, e); end
    bus_xfer(1'b0, 32'h8, 32'h0, 4'hF, rv, rd); e = exp_q.pop_front();
    total++; if (rd !== e) begin bad++; $display("FAIL post_reset_baud got %h want %h", rd, e); end
    low_seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) low_seen = 1'b1;
    end
    total++; if (low_seen) begin bad++; $display("FAIL post_reset_idle got activity want idle"); end
  endtask

  initial begin
    total = 0; bad = 0;
    test_reset();
    test_regs();
    test_tx_frame();
    test_back_to_back();
    test_rx();
    test_overrun();
    test_frame_err();
    test_irq();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
